hazard_ctrl_pipe: RTL and testbench

- Control-path sequencer for the 5-stage RISC-V pipeline.
- Takes decoded control signals and register indices from the ID stage and carries the control bits through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and taken branches/jumps, and drives stall/flush to the fetch/decode registers.
- Drives forwarding selects to the EX-stage operand muxes and counts retired instructions.

---
 rtl/hazard_ctrl_pipe_if.sv | 59 +++++
 rtl/hazard_ctrl_pipe.sv | 141 ++++++++++++++
 tb/tb_hazard_ctrl_pipe.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pipe_if.sv
// Decode-side controls into, and E/M/W controls plus hazard/forward selects out of, the pipeline sequencer.
// Master drives decode fields and ZeroE; slave returns stage controls, stall/flush, forward selects and retire count.
interface hazard_ctrl_pipe_if #(
  parameter int CNT_W = 32
);
  logic             ValidD;
  logic             RegWriteD;
  logic [1:0]       ResultSrcD;
  logic             MemWriteD;
  logic             JumpD;
  logic             BranchD;
  logic [2:0]       ALUControlD;
  logic             ALUSrcD;
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       RdD;
  logic             ZeroE;

  logic             RegWriteE;
  logic             MemWriteE;
  logic             JumpE;
  logic             BranchE;
  logic             ALUSrcE;
  logic [1:0]       ResultSrcE;
  logic [2:0]       ALUControlE;
  logic             RegWriteM;
  logic             MemWriteM;
  logic [1:0]       ResultSrcM;
  logic [4:0]       RdM;
  logic             RegWriteW;
  logic [1:0]       ResultSrcW;
  logic [4:0]       RdW;
  logic             PCSrcE;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic [CNT_W-1:0] RetireCnt;

  modport master (
    output ValidD, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD,
           ALUControlD, ALUSrcD, Rs1D, Rs2D, RdD, ZeroE,
    input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
           ALUControlE, RegWriteM, MemWriteM, ResultSrcM, RdM, RegWriteW,
           ResultSrcW, RdW, PCSrcE, StallF, StallD, FlushD, FlushE,
           ForwardAE, ForwardBE, RetireCnt
  );

  modport slave (
    input  ValidD, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD,
           ALUControlD, ALUSrcD, Rs1D, Rs2D, RdD, ZeroE,
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
           ALUControlE, RegWriteM, MemWriteM, ResultSrcM, RdM, RegWriteW,
           ResultSrcW, RdW, PCSrcE, StallF, StallD, FlushD, FlushE,
           ForwardAE, ForwardBE, RetireCnt
  );
endinterface

// File: rtl/hazard_ctrl_pipe.sv
// 5-stage control-path sequencer: E/M/W control registers, load-use and branch hazards, forwarding, retire counter.
// Controls reach E/M/W 1/2/3 cycles after decode; no backpressure beyond StallF/StallD on load-use.
module hazard_ctrl_pipe #(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard_ctrl_pipe_if.slave pif
);

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ex_ctrl_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic [4:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] result_src;
    logic [4:0] rd;
  } wb_ctrl_t;

  ex_ctrl_t         ex_q, ex_d;
  mem_ctrl_t        mem_q, mem_d;
  wb_ctrl_t         wb_q, wb_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  logic             pc_src;
  logic             lw_stall;
  logic             flush_e;

  // MEM result wins over WB because it is the younger write to the same register.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input mem_ctrl_t m,
                                         input wb_ctrl_t  w);
    logic [1:0] sel;
    sel = 2'b00;
    if (m.reg_write && (m.rd != 5'd0) && (m.rd == rs)) begin
      sel = 2'b10;
    end else if (w.reg_write && (w.rd != 5'd0) && (w.rd == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    pc_src   = (ex_q.branch & pif.ZeroE) | ex_q.jump;
    lw_stall = (ex_q.result_src == 2'b01) && (ex_q.rd != 5'd0) &&
               ((pif.Rs1D == ex_q.rd) || (pif.Rs2D == ex_q.rd));
    flush_e  = lw_stall | pc_src;
  end

  always_comb begin
    ex_d = '0;
    if (!flush_e) begin
      ex_d.valid       = pif.ValidD;
      ex_d.reg_write   = pif.RegWriteD;
      ex_d.result_src  = pif.ResultSrcD;
      ex_d.mem_write   = pif.MemWriteD;
      ex_d.jump        = pif.JumpD;
      ex_d.branch      = pif.BranchD;
      ex_d.alu_control = pif.ALUControlD;
      ex_d.alu_src     = pif.ALUSrcD;
      ex_d.rs1         = pif.Rs1D;
      ex_d.rs2         = pif.Rs2D;
      ex_d.rd          = pif.RdD;
    end
  end

  always_comb begin
    mem_d            = '0;
    mem_d.valid      = ex_q.valid;
    mem_d.reg_write  = ex_q.reg_write;
    mem_d.mem_write  = ex_q.mem_write;
    mem_d.result_src = ex_q.result_src;
    mem_d.rd         = ex_q.rd;

    wb_d             = '0;
    wb_d.valid       = mem_q.valid;
    wb_d.reg_write   = mem_q.reg_write;
    wb_d.result_src  = mem_q.result_src;
    wb_d.rd          = mem_q.rd;

    retire_cnt_d     = retire_cnt_q + CNT_W'(wb_q.valid);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q         <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      retire_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      wb_q         <= wb_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign pif.RegWriteE   = ex_q.reg_write;
  assign pif.MemWriteE   = ex_q.mem_write;
  assign pif.JumpE       = ex_q.jump;
  assign pif.BranchE     = ex_q.branch;
  assign pif.ALUSrcE     = ex_q.alu_src;
  assign pif.ResultSrcE  = ex_q.result_src;
  assign pif.ALUControlE = ex_q.alu_control;
  assign pif.RegWriteM   = mem_q.reg_write;
  assign pif.MemWriteM   = mem_q.mem_write;
  assign pif.ResultSrcM  = mem_q.result_src;
  assign pif.RdM         = mem_q.rd;
  assign pif.RegWriteW   = wb_q.reg_write;
  assign pif.ResultSrcW  = wb_q.result_src;
  assign pif.RdW         = wb_q.rd;
  assign pif.PCSrcE      = pc_src;
  assign pif.StallF      = lw_stall;
  assign pif.StallD      = lw_stall;
  assign pif.FlushD      = pc_src;
  assign pif.FlushE      = flush_e;
  assign pif.ForwardAE   = fwd_sel(ex_q.rs1, mem_q, wb_q);
  assign pif.ForwardBE   = fwd_sel(ex_q.rs2, mem_q, wb_q);
  assign pif.RetireCnt   = retire_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Directed bench for hazard_ctrl_pipe: each decode slot pushes its expected E/M/W image to a queue that is
// popped as the slot drains; stall/flush/forward expectations are written per step.
module tb_hazard_ctrl_pipe;
  localparam int CW = 4;

  typedef struct packed {
    logic       v;
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic       j;
    logic       b;
    logic [2:0] alu;
    logic       as;
    logic [4:0] r1;
    logic [4:0] r2;
    logic [4:0] rd;
  } ins_t;

  localparam ins_t NOP = '0;

  logic clk;
  logic rst_n;
  hazard_ctrl_pipe_if #(.CNT_W(CW)) pif ();

  hazard_ctrl_pipe #(.CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pif   (pif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      n_cmp = 0;
  int      n_err = 0;
  ins_t    sbq[$];
  logic [CW-1:0] exp_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(input logic rw, input logic [1:0] rs, input logic mw,
                              input logic j, input logic b,
                              input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    ins_t r;
    r.v   = 1'b1;
    r.rw  = rw;
    r.rs  = rs;
    r.mw  = mw;
    r.j   = j;
    r.b   = b;
    r.alu = rd[2:0] ^ 3'd5;
    r.as  = r2[0];
    r.r1  = r1;
    r.r2  = r2;
    r.rd  = rd;
    return r;
  endfunction

  task automatic drive(input ins_t d);
    pif.ValidD      = d.v;
    pif.RegWriteD   = d.rw;
    pif.ResultSrcD  = d.rs;
    pif.MemWriteD   = d.mw;
    pif.JumpD       = d.j;
    pif.BranchD     = d.b;
    pif.ALUControlD = d.alu;
    pif.ALUSrcD     = d.as;
    pif.Rs1D        = d.r1;
    pif.Rs2D        = d.r2;
    pif.RdD         = d.rd;
  endtask

  task automatic drive_random();
    ins_t d;
    d = ins_t'({$urandom, $urandom});
    drive(d);
    pif.ZeroE = 1'($urandom);
  endtask

  // One decode slot: drive at negedge, check combinational and staged outputs, then clock.
  task automatic tick(input ins_t d, input logic z, input logic es, input logic ep,
                      input logic [1:0] fa, input logic [1:0] fb);
    ins_t w, m, e;
    drive(d);
    pif.ZeroE = z;
    #1;
    chk("StallF", 32'(pif.StallF), 32'(es));
    chk("StallD", 32'(pif.StallD), 32'(es));
    chk("FlushD", 32'(pif.FlushD), 32'(ep));
    chk("FlushE", 32'(pif.FlushE), 32'(es | ep));
    chk("PCSrcE", 32'(pif.PCSrcE), 32'(ep));
    chk("ForwardAE", 32'(pif.ForwardAE), 32'(fa));
    chk("ForwardBE", 32'(pif.ForwardBE), 32'(fb));
    n_cmp++;
    if (sbq.size() != 3) begin
      n_err++;
      $error("FAIL sb_depth: observed %0d expected 3", sbq.size());
      sbq.delete();
      repeat (3) sbq.push_back(NOP);
    end
    w = sbq.pop_front();
    m = sbq[0];
    e = sbq[1];
    chk("RegWriteE", 32'(pif.RegWriteE), 32'(e.rw));
    chk("ResultSrcE", 32'(pif.ResultSrcE), 32'(e.rs));
    chk("MemWriteE", 32'(pif.MemWriteE), 32'(e.mw));
    chk("JumpE", 32'(pif.JumpE), 32'(e.j));
    chk("BranchE", 32'(pif.BranchE), 32'(e.b));
    chk("ALUControlE", 32'(pif.ALUControlE), 32'(e.alu));
    chk("ALUSrcE", 32'(pif.ALUSrcE), 32'(e.as));
    chk("RegWriteM", 32'(pif.RegWriteM), 32'(m.rw));
    chk("MemWriteM", 32'(pif.MemWriteM), 32'(m.mw));
    chk("ResultSrcM", 32'(pif.ResultSrcM), 32'(m.rs));
    chk("RdM", 32'(pif.RdM), 32'(m.rd));
    chk("RegWriteW", 32'(pif.RegWriteW), 32'(w.rw));
    chk("ResultSrcW", 32'(pif.ResultSrcW), 32'(w.rs));
    chk("RdW", 32'(pif.RdW), 32'(w.rd));
    chk("RetireCnt", 32'(pif.RetireCnt), 32'(exp_cnt));
    if (w.v) exp_cnt = exp_cnt + 1'b1;
    sbq.push_back((es | ep) ? NOP : d);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_RegWriteE"}, 32'(pif.RegWriteE), 0);
    chk({tag, "_MemWriteE"}, 32'(pif.MemWriteE), 0);
    chk({tag, "_JumpE"}, 32'(pif.JumpE), 0);
    chk({tag, "_BranchE"}, 32'(pif.BranchE), 0);
    chk({tag, "_ALUControlE"}, 32'(pif.ALUControlE), 0);
    chk({tag, "_RegWriteM"}, 32'(pif.RegWriteM), 0);
    chk({tag, "_MemWriteM"}, 32'(pif.MemWriteM), 0);
    chk({tag, "_RdM"}, 32'(pif.RdM), 0);
    chk({tag, "_RegWriteW"}, 32'(pif.RegWriteW), 0);
    chk({tag, "_RdW"}, 32'(pif.RdW), 0);
    chk({tag, "_RetireCnt"}, 32'(pif.RetireCnt), 0);
    chk({tag, "_PCSrcE"}, 32'(pif.PCSrcE), 0);
    chk({tag, "_StallF"}, 32'(pif.StallF), 0);
    chk({tag, "_FlushE"}, 32'(pif.FlushE), 0);
    chk({tag, "_ForwardAE"}, 32'(pif.ForwardAE), 0);
    chk({tag, "_ForwardBE"}, 32'(pif.ForwardBE), 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_random();
      @(posedge clk);
      @(negedge clk);
      drive_random();
      #1;
      check_cleared($sformatf("%s_rst%0d", tag, k));
    end
    rst_n = 1'b1;
    sbq.delete();
    repeat (3) sbq.push_back(NOP);
    exp_cnt = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(NOP);
    pif.ZeroE = 1'b0;
    exp_cnt = '0;
    @(negedge clk);
    do_reset("init");

    // Load-use: lw x5 then add x6,x5,x3
    tick(mk(1, 2'b01, 0, 0, 0, 5'd1, 5'd2, 5'd5), 0, 0, 0, 2'b00, 2'b00);
    tick(mk(1, 2'b00, 0, 0, 0, 5'd5, 5'd3, 5'd6), 0, 1, 0, 2'b00, 2'b00);
    tick(mk(1, 2'b00, 0, 0, 0, 5'd5, 5'd3, 5'd6), 0, 0, 0, 2'b00, 2'b00);
    tick(NOP, 0, 0, 0, 2'b01, 2'b00);
    tick(NOP, 0, 0, 0, 2'b00, 2'b00);

    // Forwarding priority: two writers of x7, then a reader on rs2
    tick(mk(1, 2'b00, 0, 0, 0, 5'd1, 5'd2, 5'd7), 0, 0, 0, 2'b00, 2'b00);
    tick(mk(1, 2'b00, 0, 0, 0, 5'd3, 5'd4, 5'd7), 0, 0, 0, 2'b00, 2'b00);
    tick(mk(1, 2'b00, 0, 0, 0, 5'd8, 5'd7, 5'd9), 0, 0, 0, 2'b00, 2'b00);
    tick(NOP, 0, 0, 0, 2'b00, 2'b10);
    // Younger writer targets x0, so the WB copy of x7 is used
    tick(mk(1, 2'b00, 0, 0, 0, 5'd1, 5'd2, 5'd7), 0, 0, 0, 2'b00, 2'b00);
    tick(mk(1, 2'b00, 0, 0, 0, 5'd3, 5'd4, 5'd0), 0, 0, 0, 2'b00, 2'b00);
    tick(mk(1, 2'b00, 0, 0, 0, 5'd8, 5'd7, 5'd9), 0, 0, 0, 2'b00, 2'b00);
    tick(NOP, 0, 0, 0, 2'b00, 2'b01);

    // x0 guard on forwarding and on load-use
    tick(mk(1, 2'b00, 0, 0, 0, 5'd1, 5'd2, 5'd0), 0, 0, 0, 2'b00, 2'b00);
    tick(mk(1, 2'b00, 0, 0, 0, 5'd0, 5'd5, 5'd10), 0, 0, 0, 2'b00, 2'b00);
    tick(mk(1, 2'b01, 0, 0, 0, 5'd1, 5'd2, 5'd0), 0, 0, 0, 2'b00, 2'b00);
    tick(mk(1, 2'b00, 0, 0, 0, 5'd0, 5'd0, 5'd11), 0, 0, 0, 2'b00, 2'b00);
    tick(NOP, 0, 0, 0, 2'b00, 2'b00);

    // Branch taken, branch not taken, jump with ZeroE=0
    tick(mk(0, 2'b00, 0, 0, 1, 5'd1, 5'd2, 5'd0), 0, 0, 0, 2'b00, 2'b00);
    tick(mk(1, 2'b00, 0, 0, 0, 5'd3, 5'd4, 5'd12), 1, 0, 1, 2'b00, 2'b00);
    tick(NOP, 1, 0, 0, 2'b00, 2'b00);
    tick(mk(0, 2'b00, 0, 0, 1, 5'd1, 5'd2, 5'd0), 0, 0, 0, 2'b00, 2'b00);
    tick(mk(1, 2'b00, 0, 0, 0, 5'd3, 5'd4, 5'd13), 0, 0, 0, 2'b00, 2'b00);
    tick(mk(1, 2'b10, 0, 1, 0, 5'd0, 5'd0, 5'd1), 0, 0, 0, 2'b00, 2'b00);
    tick(mk(1, 2'b00, 0, 0, 0, 5'd5, 5'd6, 5'd14), 0, 0, 1, 2'b00, 2'b00);
    tick(NOP, 1, 0, 0, 2'b00, 2'b00);

    // Store and writer in flight, then reset mid-operation
    tick(mk(0, 2'b00, 1, 0, 0, 5'd1, 5'd2, 5'd0), 0, 0, 0, 2'b00, 2'b00);
    tick(mk(1, 2'b00, 0, 0, 0, 5'd3, 5'd4, 5'd16), 0, 0, 0, 2'b00, 2'b00);
    do_reset("mid");

    // Retire counter: 20 slots with one bubble, 4-bit counter wraps
    for (int i = 0; i < 20; i++) begin
      tick((i == 10) ? NOP : mk(1, 2'b00, 0, 0, 0, 5'd0, 5'd0, 5'(i + 1)), 0, 0, 0, 2'b00, 2'b00);
    end
    repeat (4) tick(NOP, 0, 0, 0, 2'b00, 2'b00);
    chk("retire_final", 32'(pif.RetireCnt), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
